pulse_receiver_duration_capture: RTL and testbench

Receive-side counterpart of the pulse transmitter timer. It synchronises an incoming pulse-train input and measures each level segment between edges in prescaled tick units. Each completed segment is delivered as a (level, duration) sample through a single-entry valid/ready output register. A long idle-level segment is detected as a timeout, which ends the frame.

---
 rtl/pulse_transmitter_pkg.sv | 14 +
 rtl/pulse_receiver_duration_capture_if.sv | 25 ++
 rtl/pulse_receiver_input_sync.sv | 38 +++
 rtl/pulse_receiver_duration_capture.sv | 159 +++++++++++++++
 tb/tb_pulse_receiver_duration_capture.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pulse_transmitter_pkg.sv
// Definitions shared by the pulse transmitter timer and the pulse receiver:
// FSM state encoding and the prescaler select width helper.
package pulse_transmitter_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

  function automatic int presc_sel_width(input int prescaler_width);
    return $clog2(prescaler_width + 1);
  endfunction

endpackage

// File: rtl/pulse_receiver_duration_capture_if.sv
// Sample output channel: one (level, duration) sample per valid/ready transfer.
interface pulse_receiver_duration_capture_if #(
  parameter int TIMER_WIDTH = 8
) ();

  logic                   sample_valid;
  logic                   sample_level;
  logic [TIMER_WIDTH-1:0] sample_duration;
  logic                   sample_ready;

  modport master (
    output sample_valid,
    output sample_level,
    output sample_duration,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_level,
    input  sample_duration,
    output sample_ready
  );

endinterface

// File: rtl/pulse_receiver_input_sync.sv
// Multi-flop synchroniser for the asynchronous pulse input plus an any-edge
// detector; level and edge leave registered and aligned to each other.
module pulse_receiver_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic sig_i,
  output logic sig_s_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sig_d_q;
  logic                   edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
      edge_q  <= 1'b0;
    end else if (!en_i) begin
      sync_q  <= '0;
      sig_d_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      sig_d_q <= sync_q[SYNC_STAGES-1];
      // edge_q and sig_d_q update together, so edge_o qualifies the new level
      edge_q  <= sync_q[SYNC_STAGES-1] ^ sig_d_q;
    end
  end

  assign sig_s_o = sig_d_q;
  assign edge_o  = edge_q;

endmodule

// File: rtl/pulse_receiver_duration_capture.sv
// Measures each level segment of a synchronised pulse train in prescaled ticks
// and delivers (level, duration) samples through a single-entry output register.
module pulse_receiver_duration_capture
  import pulse_transmitter_pkg::*;
#(
  parameter int PRESCALER_WIDTH = 15,
  parameter int TIMER_WIDTH     = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                                        clk,
  input  logic                                        sys_rst,
  input  logic                                        en,
  input  logic [presc_sel_width(PRESCALER_WIDTH)-1:0] prescaler,
  input  logic                                        idle_level,
  input  logic [TIMER_WIDTH-1:0]                      timeout,
  input  logic                                        sig_in,
  pulse_receiver_duration_capture_if.master           smp,
  output logic                                        overrun,
  output logic                                        frame_end,
  output logic                                        idle
);

  localparam logic [TIMER_WIDTH-1:0] DUR_MAX = '1;

  logic sig_s;
  logic sig_edge;

  pulse_receiver_input_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (sys_rst),
    .en_i   (en),
    .sig_i  (sig_in),
    .sig_s_o(sig_s),
    .edge_o (sig_edge)
  );

  state_e                     state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] presc_q, presc_d, presc_cur, presc_max;
  logic [TIMER_WIDTH-1:0]     dur_q, dur_d, dur_base;
  logic                       seg_level_q, seg_level_d;
  logic                       emit_q, emit_d;
  logic                       emit_level_q, emit_level_d;
  logic [TIMER_WIDTH-1:0]     emit_dur_q, emit_dur_d;
  logic                       frame_end_q, frame_end_d;
  logic                       tick;

  logic                       valid_q;
  logic                       level_q;
  logic [TIMER_WIDTH-1:0]     duration_q;
  logic                       overrun_q;

  assign presc_max = PRESCALER_WIDTH'((32'd1 << prescaler) - 32'd1);

  // The edge cycle itself is the first counted cycle of the new segment.
  always_comb begin
    presc_cur    = sig_edge ? '0 : presc_q;
    dur_base     = sig_edge ? '0 : dur_q;
    tick         = (presc_cur == presc_max);
    presc_d      = tick ? '0 : presc_cur + PRESCALER_WIDTH'(1);
    dur_d        = (tick && dur_base != DUR_MAX) ? dur_base + TIMER_WIDTH'(1) : dur_base;
    state_d      = state_q;
    seg_level_d  = seg_level_q;
    emit_d       = 1'b0;
    emit_level_d = emit_level_q;
    emit_dur_d   = emit_dur_q;
    frame_end_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sig_edge && sig_s != idle_level) begin
          state_d     = ST_MEASURE;
          seg_level_d = sig_s;
        end else begin
          presc_d = '0;
          dur_d   = '0;
        end
      end
      ST_MEASURE: begin
        if (sig_edge) begin
          emit_d       = 1'b1;
          emit_level_d = seg_level_q;
          emit_dur_d   = dur_q;
          seg_level_d  = sig_s;
        end else if (seg_level_q == idle_level && timeout != '0 && dur_q >= timeout) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          presc_d     = '0;
          dur_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      dur_q        <= '0;
      seg_level_q  <= 1'b0;
      emit_q       <= 1'b0;
      emit_level_q <= 1'b0;
      emit_dur_q   <= '0;
      frame_end_q  <= 1'b0;
    end else if (!en) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      dur_q        <= '0;
      seg_level_q  <= 1'b0;
      emit_q       <= 1'b0;
      emit_level_q <= 1'b0;
      emit_dur_q   <= '0;
      frame_end_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      dur_q        <= dur_d;
      seg_level_q  <= seg_level_d;
      emit_q       <= emit_d;
      emit_level_q <= emit_level_d;
      emit_dur_q   <= emit_dur_d;
      frame_end_q  <= frame_end_d;
    end
  end

  // A held sample is only replaced when the consumer takes it in the same cycle.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      valid_q    <= 1'b0;
      level_q    <= 1'b0;
      duration_q <= '0;
      overrun_q  <= 1'b0;
    end else if (!en) begin
      valid_q    <= 1'b0;
      level_q    <= 1'b0;
      duration_q <= '0;
      overrun_q  <= 1'b0;
    end else if (emit_q) begin
      if (!valid_q || smp.sample_ready) begin
        valid_q    <= 1'b1;
        level_q    <= emit_level_q;
        duration_q <= emit_dur_q;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (smp.sample_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign smp.sample_valid    = valid_q;
  assign smp.sample_level    = level_q;
  assign smp.sample_duration = duration_q;
  assign overrun             = overrun_q;
  assign frame_end           = frame_end_q;
  assign idle                = (state_q == ST_IDLE);

endmodule

// File: tb/tb_pulse_receiver_duration_capture.sv
// Scoreboard bench: expected samples are queued as segments are driven and
// compared when the DUT hands a sample over.
module tb_pulse_receiver_duration_capture;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       en;
  logic [3:0] prescaler;
  logic       idle_level;
  logic [7:0] timeout;
  logic       sig_in;
  logic       overrun;
  logic       frame_end;
  logic       idle;

  pulse_receiver_duration_capture_if #(.TIMER_WIDTH(8)) smp_if ();

  pulse_receiver_duration_capture dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .en        (en),
    .prescaler (prescaler),
    .idle_level(idle_level),
    .timeout   (timeout),
    .sig_in    (sig_in),
    .smp       (smp_if),
    .overrun   (overrun),
    .frame_end (frame_end),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       level;
    logic [7:0] dur;
  } sample_t;

  sample_t exp_q[$];
  sample_t mon_exp;
  int      checks  = 0;
  int      errors  = 0;
  int      fe_cnt  = 0;
  int      fe_base = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic lvl, input int n);
    sig_in = lvl;
    cycles(n);
  endtask

  task automatic expect_sample(input logic lvl, input logic [7:0] dur);
    sample_t s;
    s.level = lvl;
    s.dur   = dur;
    exp_q.push_back(s);
  endtask

  always @(negedge clk) begin
    if (frame_end === 1'b1) fe_cnt++;
    if (smp_if.sample_valid === 1'b1 && smp_if.sample_ready === 1'b1) begin
      $display("sample level=%0d duration=%0d", smp_if.sample_level, smp_if.sample_duration);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_sample", 32'(exp_q.size()), 1);
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("sample_level", smp_if.sample_level, mon_exp.level);
        check_eq("sample_duration", smp_if.sample_duration, mon_exp.dur);
      end
    end
  end

  initial begin
    sys_rst = 1'b1; en = 1'b0; prescaler = 4'd0; idle_level = 1'b0;
    timeout = 8'd20; sig_in = 1'b0; smp_if.sample_ready = 1'b1;
    cycles(1);
    check_eq("rst_idle", idle, 1);
    check_eq("rst_valid", smp_if.sample_valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_frame_end", frame_end, 0);
    sys_rst = 1'b0;
    cycles(1);
    en = 1'b1;
    cycles(3);

    // basic sample then timeout
    fe_base = fe_cnt;
    expect_sample(1'b1, 8'd10);
    seg(1'b1, 10);
    seg(1'b0, 40);
    check_eq("t1_frame_end", 32'(fe_cnt - fe_base), 1);
    check_eq("t1_idle", idle, 1);
    check_eq("t1_drain", 32'(exp_q.size()), 0);

    // prescaler 2
    en = 1'b0; prescaler = 4'd2;
    cycles(2);
    en = 1'b1;
    cycles(2);
    fe_base = fe_cnt;
    expect_sample(1'b1, 8'd9);
    seg(1'b1, 37);
    expect_sample(1'b0, 8'd4);
    seg(1'b0, 16);
    seg(1'b1, 10);
    check_eq("t2_drain", 32'(exp_q.size()), 0);
    check_eq("t2_no_frame_end", 32'(fe_cnt - fe_base), 0);
    en = 1'b0; sig_in = 1'b0; prescaler = 4'd0; timeout = 8'd0;
    cycles(3);

    // saturation, timeout disabled
    en = 1'b1;
    cycles(2);
    fe_base = fe_cnt;
    expect_sample(1'b1, 8'd255);
    seg(1'b1, 300);
    seg(1'b0, 60);
    check_eq("t3_drain", 32'(exp_q.size()), 0);
    check_eq("t3_no_frame_end", 32'(fe_cnt - fe_base), 0);
    check_eq("t3_still_measuring", idle, 0);
    en = 1'b0; smp_if.sample_ready = 1'b0;
    cycles(2);

    // backpressure and overrun
    en = 1'b1;
    cycles(2);
    seg(1'b1, 5);
    seg(1'b0, 6);
    seg(1'b1, 8);
    check_eq("t4_valid_held", smp_if.sample_valid, 1);
    check_eq("t4_level_held", smp_if.sample_level, 1);
    check_eq("t4_dur_held", smp_if.sample_duration, 5);
    check_eq("t4_overrun", overrun, 1);
    cycles(5);
    check_eq("t4_dur_stable", smp_if.sample_duration, 5);
    expect_sample(1'b1, 8'd5);
    smp_if.sample_ready = 1'b1;
    cycles(1);
    check_eq("t4_valid_drop", smp_if.sample_valid, 0);
    check_eq("t4_overrun_sticky", overrun, 1);
    en = 1'b0;
    cycles(1);
    check_eq("t4_overrun_cleared", overrun, 0);
    sig_in = 1'b0;
    cycles(3);

    // back-to-back with ready tied high
    en = 1'b1;
    cycles(2);
    expect_sample(1'b1, 8'd3);
    seg(1'b1, 3);
    expect_sample(1'b0, 8'd3);
    seg(1'b0, 3);
    expect_sample(1'b1, 8'd3);
    seg(1'b1, 3);
    seg(1'b0, 10);
    check_eq("t5_drain", 32'(exp_q.size()), 0);
    check_eq("t5_no_overrun", overrun, 0);

    // asynchronous reset mid-measurement
    smp_if.sample_ready = 1'b0;
    seg(1'b1, 4);
    seg(1'b0, 6);
    check_eq("t6_pre_valid", smp_if.sample_valid, 1);
    @(negedge clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check_eq("t6_rst_valid", smp_if.sample_valid, 0);
    check_eq("t6_rst_frame_end", frame_end, 0);
    check_eq("t6_rst_overrun", overrun, 0);
    check_eq("t6_rst_idle", idle, 1);
    @(posedge clk);
    #1;
    sys_rst = 1'b0; smp_if.sample_ready = 1'b1;
    cycles(3);
    expect_sample(1'b1, 8'd7);
    seg(1'b1, 7);
    seg(1'b0, 10);
    check_eq("t6_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
